// File: rtl/dsi_pkt_rx_checker.sv
// dsi_pkt_rx_checker
// Byte-serial MIPI DSI receive-path packet parser and integrity checker.
// Splits the lane byte stream into packets and checks the 24-bit header
// against its 6-bit Hamming ECC. Long-packet payload is forwarded byte by
// byte, and the trailing CRC-16 is checked against a running byte_crc.
//
// Build option: define DSI_RX_ECC_CORRECT_EN to enable single-bit header
// correction. When it is left undefined the header ECC is detection-only.

module dsi_pkt_rx_checker (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_sot,
  input  logic        rx_eot,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        hdr_valid,
  output logic [7:0]  hdr_di,
  output logic [15:0] hdr_wc,
  output logic        hdr_long,
  output logic        ecc_corrected,
  output logic        ecc_error,
  output logic        pld_valid,
  output logic [7:0]  pld_data,
  output logic        pld_last,
  output logic        crc_valid,
  output logic        crc_error,
  output logic        pkt_abort
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PLD  = 3'd2,
    ST_CRC  = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  // Parity bits P0..P5 of the DSI header ECC; P6/P7 are always zero on the wire.
  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // CRC-16-CCITT (x^16+x^12+x^5+1), bits consumed LSB first, reflected form.
  function automatic logic [15:0] byte_crc(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[15:1]};
      if (fb) begin
        c = c ^ 16'h8408;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  state_t      state_r, state_nxt;
  logic [1:0]  cnt_r, cnt_nxt;
  logic [7:0]  hb0_r, hb0_nxt;
  logic [7:0]  hb1_r, hb1_nxt;
  logic [7:0]  hb2_r, hb2_nxt;
  logic [15:0] pld_cnt_r, pld_cnt_nxt;
  logic [15:0] crc_r, crc_nxt;
  logic [7:0]  crc_lo_r, crc_lo_nxt;

  logic        hdr_valid_nxt;
  logic [7:0]  hdr_di_nxt;
  logic [15:0] hdr_wc_nxt;
  logic        hdr_long_nxt;
  logic        ecc_corrected_nxt;
  logic        ecc_error_nxt;
  logic        pld_valid_nxt;
  logic [7:0]  pld_data_nxt;
  logic        pld_last_nxt;
  logic        crc_valid_nxt;
  logic        crc_error_nxt;
  logic        pkt_abort_nxt;

  // Header check datapath: the ECC byte is the live rx_data byte when cnt_r == 3.
  logic [23:0] h_raw_s;
  logic [23:0] h_fix_s;
  logic [5:0]  ecc_calc_s;
  logic [5:0]  syn_s;
  logic        ecc_corr_s;
  logic        ecc_err_s;
  logic        hdr_long_s;
  logic        abortable_s;
  logic [15:0] crc_rx_s;

  assign h_raw_s    = {hb2_r, hb1_r, hb0_r};
  assign ecc_calc_s = ecc_calc(h_raw_s);
  assign syn_s      = ecc_calc_s ^ rx_data[5:0];
  assign hdr_long_s = h_fix_s[3] & (|h_fix_s[2:0]);
  assign crc_rx_s   = {rx_data, crc_lo_r};

  // A packet in flight is cut only if some of its bytes were already accepted.
  assign abortable_s = (state_r == ST_PLD) || (state_r == ST_CRC) ||
                       ((state_r == ST_HDR) && (cnt_r != 2'd0));

`ifdef DSI_RX_ECC_CORRECT_EN
  logic [5:0] col_syn_s;
  logic       col_hit_s;
  logic       syn_one_s;

  assign syn_one_s = (syn_s != 6'd0) && ((syn_s & (syn_s - 6'd1)) == 6'd0);

  // Locate a single flipped header bit by matching the syndrome to its column.
  always_comb begin
    h_fix_s   = h_raw_s;
    col_hit_s = 1'b0;
    col_syn_s = 6'd0;
    for (int i = 0; i < 24; i++) begin
      col_syn_s = ecc_calc(24'd1 << i);
      if (syn_s == col_syn_s) begin
        h_fix_s[i] = ~h_raw_s[i];
        col_hit_s  = 1'b1;
      end else begin
        h_fix_s[i] = h_fix_s[i];
      end
    end
    ecc_corr_s = col_hit_s | syn_one_s;
    ecc_err_s  = (syn_s != 6'd0) & ~ecc_corr_s;
  end
`else
  // Detection only: any non-zero syndrome condemns the header as received.
  always_comb begin
    h_fix_s    = h_raw_s;
    ecc_corr_s = 1'b0;
    ecc_err_s  = (syn_s != 6'd0);
  end
`endif

  // Next-state and next-output logic for the packet parser.
  always_comb begin
    state_nxt         = state_r;
    cnt_nxt           = cnt_r;
    hb0_nxt           = hb0_r;
    hb1_nxt           = hb1_r;
    hb2_nxt           = hb2_r;
    pld_cnt_nxt       = pld_cnt_r;
    crc_nxt           = crc_r;
    crc_lo_nxt        = crc_lo_r;
    hdr_valid_nxt     = 1'b0;
    hdr_di_nxt        = hdr_di;
    hdr_wc_nxt        = hdr_wc;
    hdr_long_nxt      = hdr_long;
    ecc_corrected_nxt = ecc_corrected;
    ecc_error_nxt     = ecc_error;
    pld_valid_nxt     = 1'b0;
    pld_data_nxt      = pld_data;
    pld_last_nxt      = 1'b0;
    crc_valid_nxt     = 1'b0;
    crc_error_nxt     = crc_error;
    pkt_abort_nxt     = 1'b0;

    if (rx_sot) begin
      // Start of transmission wins over everything and may carry header byte 0.
      pkt_abort_nxt = abortable_s;
      state_nxt     = ST_HDR;
      if (rx_valid) begin
        hb0_nxt = rx_data;
        cnt_nxt = 2'd1;
      end else begin
        cnt_nxt = 2'd0;
      end
    end else if (rx_eot) begin
      pkt_abort_nxt = abortable_s;
      state_nxt     = ST_IDLE;
      cnt_nxt       = 2'd0;
    end else if (rx_valid) begin
      case (state_r)
        ST_HDR: begin
          case (cnt_r)
            2'd0: begin
              hb0_nxt = rx_data;
              cnt_nxt = 2'd1;
            end
            2'd1: begin
              hb1_nxt = rx_data;
              cnt_nxt = 2'd2;
            end
            2'd2: begin
              hb2_nxt = rx_data;
              cnt_nxt = 2'd3;
            end
            default: begin
              hdr_valid_nxt     = 1'b1;
              hdr_di_nxt        = h_fix_s[7:0];
              hdr_wc_nxt        = h_fix_s[23:8];
              hdr_long_nxt      = hdr_long_s;
              ecc_corrected_nxt = ecc_corr_s;
              ecc_error_nxt     = ecc_err_s;
              cnt_nxt           = 2'd0;
              pld_cnt_nxt       = h_fix_s[23:8];
              crc_nxt           = 16'hFFFF;
              if (ecc_err_s) begin
                state_nxt = ST_DROP;
              end else if (!hdr_long_s) begin
                state_nxt = ST_HDR;
              end else if (h_fix_s[23:8] == 16'd0) begin
                state_nxt = ST_CRC;
              end else begin
                state_nxt = ST_PLD;
              end
            end
          endcase
        end
        ST_PLD: begin
          pld_valid_nxt = 1'b1;
          pld_data_nxt  = rx_data;
          pld_last_nxt  = (pld_cnt_r == 16'd1);
          crc_nxt       = byte_crc(crc_r, rx_data);
          pld_cnt_nxt   = pld_cnt_r - 16'd1;
          if (pld_cnt_r == 16'd1) begin
            state_nxt = ST_CRC;
            cnt_nxt   = 2'd0;
          end else begin
            state_nxt = ST_PLD;
          end
        end
        ST_CRC: begin
          if (cnt_r == 2'd0) begin
            crc_lo_nxt = rx_data;
            cnt_nxt    = 2'd1;
          end else begin
            crc_valid_nxt = 1'b1;
            // An all-zero checksum means the transmitter did not generate one.
            crc_error_nxt = (crc_rx_s != crc_r) && (crc_rx_s != 16'h0000);
            cnt_nxt       = 2'd0;
            state_nxt     = ST_HDR;
          end
        end
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_DROP: begin
          state_nxt = ST_DROP;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 2'd0;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 2'd0;
      hb0_r         <= 8'd0;
      hb1_r         <= 8'd0;
      hb2_r         <= 8'd0;
      pld_cnt_r     <= 16'd0;
      crc_r         <= 16'd0;
      crc_lo_r      <= 8'd0;
      hdr_valid     <= 1'b0;
      hdr_di        <= 8'd0;
      hdr_wc        <= 16'd0;
      hdr_long      <= 1'b0;
      ecc_corrected <= 1'b0;
      ecc_error     <= 1'b0;
      pld_valid     <= 1'b0;
      pld_data      <= 8'd0;
      pld_last      <= 1'b0;
      crc_valid     <= 1'b0;
      crc_error     <= 1'b0;
      pkt_abort     <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      cnt_r         <= cnt_nxt;
      hb0_r         <= hb0_nxt;
      hb1_r         <= hb1_nxt;
      hb2_r         <= hb2_nxt;
      pld_cnt_r     <= pld_cnt_nxt;
      crc_r         <= crc_nxt;
      crc_lo_r      <= crc_lo_nxt;
      hdr_valid     <= hdr_valid_nxt;
      hdr_di        <= hdr_di_nxt;
      hdr_wc        <= hdr_wc_nxt;
      hdr_long      <= hdr_long_nxt;
      ecc_corrected <= ecc_corrected_nxt;
      ecc_error     <= ecc_error_nxt;
      pld_valid     <= pld_valid_nxt;
      pld_data      <= pld_data_nxt;
      pld_last      <= pld_last_nxt;
      crc_valid     <= crc_valid_nxt;
      crc_error     <= crc_error_nxt;
      pkt_abort     <= pkt_abort_nxt;
    end
  end

endmodule

// File: tb/tb_dsi_pkt_rx_checker.sv
// Self-checking bench for dsi_pkt_rx_checker: expected header, payload, CRC
// and abort events are queued as stimulus is driven and compared as the DUT
// emits them. Expectations follow DSI_RX_ECC_CORRECT_EN if it is defined.

module tb_dsi_pkt_rx_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_sot;
  logic        rx_eot;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        hdr_valid;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic        hdr_long;
  logic        ecc_corrected;
  logic        ecc_error;
  logic        pld_valid;
  logic [7:0]  pld_data;
  logic        pld_last;
  logic        crc_valid;
  logic        crc_error;
  logic        pkt_abort;

  always #5 clk = ~clk;

  dsi_pkt_rx_checker dut (
    .clk(clk), .reset(reset), .rx_sot(rx_sot), .rx_eot(rx_eot),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .hdr_valid(hdr_valid), .hdr_di(hdr_di), .hdr_wc(hdr_wc), .hdr_long(hdr_long),
    .ecc_corrected(ecc_corrected), .ecc_error(ecc_error),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_last(pld_last),
    .crc_valid(crc_valid), .crc_error(crc_error), .pkt_abort(pkt_abort)
  );

  typedef struct {
    logic [7:0]  di;
    logic [15:0] wc;
    logic        lng;
    logic        corr;
    logic        err;
  } hdr_exp_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } pld_exp_t;

  hdr_exp_t hdr_q[$];
  pld_exp_t pld_q[$];
  logic     crc_q[$];
  int       abort_exp = 0;
  int       n_checks  = 0;
  int       n_fail    = 0;
  hdr_exp_t he;
  pld_exp_t pe;
  logic     ce;
  logic [7:0] pld_buf [16];

  // Syndrome contributed by each header bit D0..D23.
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ecc_model(input logic [23:0] h);
    logic [5:0] p;
    p = 6'd0;
    for (int i = 0; i < 24; i++) if (h[i]) p = p ^ ECC_COL[i];
    return {2'b00, p};
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 16'h8408) : (x >> 1);
    return x;
  endfunction

  task automatic cyc(input logic s, input logic e, input logic v, input logic [7:0] d);
    rx_sot = s; rx_eot = e; rx_valid = v; rx_data = d;
    @(posedge clk); #1;
    rx_sot = 1'b0; rx_eot = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_hdr(input logic s, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    cyc(s, 1'b0, 1'b1, b0);
    cyc(1'b0, 1'b0, 1'b1, b1);
    cyc(1'b0, 1'b0, 1'b1, b2);
    cyc(1'b0, 1'b0, 1'b1, b3);
  endtask

  task automatic exp_hdr(input logic [7:0] di, input logic [15:0] wc,
                         input logic lng, input logic corr, input logic err);
    hdr_exp_t h;
    h.di = di; h.wc = wc; h.lng = lng; h.corr = corr; h.err = err;
    hdr_q.push_back(h);
  endtask

  // Long packet DI 0x39 with n payload bytes from pld_buf; byte bad_idx is
  // corrupted on the wire after the transmitter's CRC was computed.
  task automatic send_long(input logic s, input int n, input int bad_idx,
                           input logic use_force, input logic [15:0] crc_force, input logic gap);
    logic [15:0] wc, tx_crc, rx_crc, sent;
    logic [7:0]  b;
    pld_exp_t    p;
    wc = 16'(n);
    exp_hdr(8'h39, wc, 1'b1, 1'b0, 1'b0);
    send_hdr(s, 8'h39, wc[7:0], wc[15:8], ecc_model({wc, 8'h39}));
    tx_crc = 16'hFFFF;
    rx_crc = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = pld_buf[i] ^ ((i == bad_idx) ? 8'h01 : 8'h00);
      tx_crc = crc_model(tx_crc, pld_buf[i]);
      rx_crc = crc_model(rx_crc, b);
      p.data = b; p.last = (i == n - 1);
      pld_q.push_back(p);
      cyc(1'b0, 1'b0, 1'b1, b);
      if (gap && i == 0) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    end
    sent = use_force ? crc_force : tx_crc;
    crc_q.push_back((sent != rx_crc) && (sent != 16'h0000));
    cyc(1'b0, 1'b0, 1'b1, sent[7:0]);
    cyc(1'b0, 1'b0, 1'b1, sent[15:8]);
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_hdr_valid"}, 32'(hdr_valid), 32'd0);
    check_val({pfx, "_hdr_di"}, 32'(hdr_di), 32'd0);
    check_val({pfx, "_hdr_wc"}, 32'(hdr_wc), 32'd0);
    check_val({pfx, "_hdr_long"}, 32'(hdr_long), 32'd0);
    check_val({pfx, "_ecc_corrected"}, 32'(ecc_corrected), 32'd0);
    check_val({pfx, "_ecc_error"}, 32'(ecc_error), 32'd0);
    check_val({pfx, "_pld_valid"}, 32'(pld_valid), 32'd0);
    check_val({pfx, "_pld_data"}, 32'(pld_data), 32'd0);
    check_val({pfx, "_pld_last"}, 32'(pld_last), 32'd0);
    check_val({pfx, "_crc_valid"}, 32'(crc_valid), 32'd0);
    check_val({pfx, "_crc_error"}, 32'(crc_error), 32'd0);
    check_val({pfx, "_pkt_abort"}, 32'(pkt_abort), 32'd0);
  endtask

  // Scoreboard: compare every output event against the queued expectation.
  always @(negedge clk) begin
    if (hdr_valid === 1'b1) begin
      if (hdr_q.size() == 0) check_val("hdr_unexpected", 32'd1, 32'd0);
      else begin
        he = hdr_q.pop_front();
        check_val("hdr_di", 32'(hdr_di), 32'(he.di));
        check_val("hdr_wc", 32'(hdr_wc), 32'(he.wc));
        check_val("hdr_long", 32'(hdr_long), 32'(he.lng));
        check_val("ecc_corrected", 32'(ecc_corrected), 32'(he.corr));
        check_val("ecc_error", 32'(ecc_error), 32'(he.err));
      end
    end
    if (pld_valid === 1'b1) begin
      if (pld_q.size() == 0) check_val("pld_unexpected", 32'd1, 32'd0);
      else begin
        pe = pld_q.pop_front();
        check_val("pld_data", 32'(pld_data), 32'(pe.data));
        check_val("pld_last", 32'(pld_last), 32'(pe.last));
      end
    end
    if (crc_valid === 1'b1) begin
      if (crc_q.size() == 0) check_val("crc_unexpected", 32'd1, 32'd0);
      else begin
        ce = crc_q.pop_front();
        check_val("crc_error", 32'(crc_error), 32'(ce));
      end
    end
    if (pkt_abort === 1'b1) begin
      check_val("abort_expected", 32'(abort_exp > 0), 32'd1);
      if (abort_exp > 0) abort_exp--;
    end
  end

  initial begin
    reset = 1'b1; rx_sot = 1'b0; rx_eot = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    pld_buf[0] = 8'hA1; pld_buf[1] = 8'hB2; pld_buf[2] = 8'hC3; pld_buf[3] = 8'h5A;
    for (int i = 4; i < 16; i++) pld_buf[i] = 8'(i * 7);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // Clean short packet, then a second header in the same burst.
    exp_hdr(8'h05, 16'h0011, 1'b0, 1'b0, 1'b0);
    send_hdr(1'b1, 8'h05, 8'h11, 8'h00, 8'h36);
    exp_hdr(8'h05, 16'h1234, 1'b0, 1'b0, 1'b0);
    send_hdr(1'b0, 8'h05, 8'h34, 8'h12, ecc_model(24'h123405));
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // Single flipped data bit, then a single flipped ECC bit.
`ifdef DSI_RX_ECC_CORRECT_EN
    exp_hdr(8'h05, 16'h0011, 1'b0, 1'b1, 1'b0);
    send_hdr(1'b1, 8'h15, 8'h11, 8'h00, 8'h36);
    exp_hdr(8'h05, 16'h0011, 1'b0, 1'b0, 1'b0);
    send_hdr(1'b0, 8'h05, 8'h11, 8'h00, 8'h36);
    exp_hdr(8'h05, 16'h0011, 1'b0, 1'b1, 1'b0);
`else
    exp_hdr(8'h15, 16'h0011, 1'b0, 1'b0, 1'b1);
    send_hdr(1'b1, 8'h15, 8'h11, 8'h00, 8'h36);
    send_hdr(1'b0, 8'h05, 8'h11, 8'h00, 8'h36);
    exp_hdr(8'h05, 16'h0011, 1'b0, 1'b0, 1'b1);
`endif
    send_hdr(1'b1, 8'h05, 8'h11, 8'h00, 8'h32);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // Double error: header flagged, following bytes dropped until next sot.
    exp_hdr(8'h06, 16'h0011, 1'b0, 1'b0, 1'b1);
    send_hdr(1'b1, 8'h06, 8'h11, 8'h00, 8'h36);
    send_hdr(1'b0, 8'h05, 8'h11, 8'h00, 8'h36);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // Zero-length long packets: matching, wrong and "not generated" CRCs.
    send_long(1'b1, 0, -1, 1'b1, 16'hFFFF, 1'b0);
    send_long(1'b0, 0, -1, 1'b1, 16'hFFFE, 1'b0);
    send_long(1'b0, 0, -1, 1'b1, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // Three-byte payload with a gap, corrupted copy, and a one-byte payload.
    send_long(1'b1, 3, -1, 1'b0, 16'h0000, 1'b1);
    send_long(1'b0, 3, 1, 1'b0, 16'h0000, 1'b0);
    send_long(1'b0, 1, -1, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // eot after two payload bytes aborts; later bytes are ignored in IDLE.
    exp_hdr(8'h39, 16'h0004, 1'b1, 1'b0, 1'b0);
    send_hdr(1'b1, 8'h39, 8'h04, 8'h00, ecc_model(24'h000439));
    pld_q.push_back('{data: 8'h11, last: 1'b0});
    cyc(1'b0, 1'b0, 1'b1, 8'h11);
    pld_q.push_back('{data: 8'h22, last: 1'b0});
    cyc(1'b0, 1'b0, 1'b1, 8'h22);
    abort_exp++;
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    send_hdr(1'b0, 8'h05, 8'h11, 8'h00, 8'h36);

    // sot in the middle of the CRC aborts and its byte starts the next header.
    exp_hdr(8'h39, 16'h0000, 1'b1, 1'b0, 1'b0);
    send_hdr(1'b1, 8'h39, 8'h00, 8'h00, 8'h0F);
    cyc(1'b0, 1'b0, 1'b1, 8'hFF);
    abort_exp++;
    exp_hdr(8'h05, 16'h0011, 1'b0, 1'b0, 1'b0);
    send_hdr(1'b1, 8'h05, 8'h11, 8'h00, 8'h36);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // Reset in the middle of a payload clears every output on the next cycle.
    exp_hdr(8'h39, 16'h0004, 1'b1, 1'b0, 1'b0);
    send_hdr(1'b1, 8'h39, 8'h04, 8'h00, ecc_model(24'h000439));
    pld_q.push_back('{data: 8'h77, last: 1'b0});
    cyc(1'b0, 1'b0, 1'b1, 8'h77);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    reset = 1'b0;
    send_hdr(1'b0, 8'h05, 8'h11, 8'h00, 8'h36);

    repeat (5) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("hdr_q_left", 32'(hdr_q.size()), 32'd0);
    check_val("pld_q_left", 32'(pld_q.size()), 32'd0);
    check_val("crc_q_left", 32'(crc_q.size()), 32'd0);
    check_val("abort_left", 32'(abort_exp), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsi_pkt_rx_checker.md
# dsi_pkt_rx_checker

Byte-serial MIPI DSI packet parser and integrity checker for the receive path (peripheral-side loopback and host-side read-response path). It takes the de-serialized lane byte stream and splits it into packets. For each header it checks the ECC against the `ecc_calc` parity equations and corrects single-bit errors. For each long packet it forwards the payload and checks the trailing CRC-16 with chained `byte_crc`. It sits between the lane merger and the packet decoder/register interface.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high reset
- `rx_sot`  in  1  start-of-transmission pulse; restarts parsing
- `rx_eot`  in  1  end-of-transmission pulse
- `rx_valid`  in  1  `rx_data` holds a byte this cycle; no backpressure
- `rx_data`  in  8  lane byte, LSB-first packet order
- `hdr_valid`  out  1  one-cycle pulse: header fields valid
- `hdr_di`  out  8  data identifier (after correction)
- `hdr_wc`  out  16  word count / short-packet data {byte2, byte1} (after correction)
- `hdr_long`  out  1  header is a long packet
- `ecc_corrected`  out  1  qualified by `hdr_valid`; single-bit error fixed
- `ecc_error`  out  1  qualified by `hdr_valid`; uncorrectable header
- `pld_valid`  out  1  payload byte strobe
- `pld_data`  out  8  payload byte
- `pld_last`  out  1  with `pld_valid`: last payload byte
- `crc_valid`  out  1  one-cycle pulse: CRC result valid
- `crc_error`  out  1  qualified by `crc_valid`
- `pkt_abort`  out  1  one-cycle pulse: packet cut by `rx_eot` or `rx_sot`

## Operation
- States: IDLE, HDR, PLD, CRC, DROP.
  - IDLE: wait for `rx_sot`.
  - HDR: collect 4 bytes (DI, WC LSB, WC MSB, ECC); byte counter 0..3.
  - PLD: forward WC bytes.
  - CRC: collect 2 bytes, LSB first.
  - DROP: ignore bytes until `rx_sot`.
- `rx_sot` in any state forces HDR with counter 0. A byte with `rx_valid` in the same cycle is header byte 0. If the state was PLD/CRC, or HDR with counter ≠ 0, pulse `pkt_abort`.
- `rx_eot` in any state forces IDLE, with `pkt_abort` under the same rule. If `rx_sot` and `rx_eot` are asserted together, `rx_sot` wins.
- Header check:
  - H = {byte2, byte1, byte0}; syndrome S = `ecc_calc(H)[5:0]` ^ byte3[5:0]; byte3[7:6] ignored.
  - S == 0: clean.
  - S equals `ecc_calc(1<<i)` for some i in 0..23: flip H[i], set `ecc_corrected`.
  - S has exactly one bit set: the ECC byte itself is in error; H is unchanged, set `ecc_corrected`.
  - Any other S: `ecc_error`=1, go to DROP.
- Long-packet rule: `hdr_long` = DT[3] & |DT[2:0], where DT = `hdr_di`[5:0].
  - Short packet, or `ecc_error`: no payload/CRC phase. A clean short packet returns to HDR for the next packet in the burst.
  - Long with WC > 0: PLD. Long with WC == 0: go directly to CRC.
- CRC:
  - Register initialised to 16'hFFFF at each header.
  - Each payload byte updates it through `byte_crc`.
  - Received value = {CRC byte1, CRC byte0}.
  - `crc_error` = (received ≠ computed) && (received ≠ 16'h0000); 0x0000 means "checksum not generated".
  - After CRC: return to HDR.
- Payload counter is 16 bits and counts down from WC. `pld_last` is asserted when the counter reaches 1.

## Timing
- Every output resets to 0 and the state resets to IDLE.
- `hdr_*` and the ECC flags are registered. `hdr_valid` pulses one cycle after the 4th header byte is accepted; fields hold until the next `hdr_valid`.
- `pld_valid`/`pld_data` follow each accepted payload byte by one cycle. Gaps in `rx_valid` propagate unchanged.
- `crc_valid` pulses one cycle after the 2nd CRC byte is accepted.
- `pkt_abort` is registered, one cycle after the `rx_sot`/`rx_eot` edge. No `crc_valid` is issued for an aborted packet.
- Back-to-back packets with no idle cycles are supported at 1 byte/clk.

## Configuration
- `DSI_RX_ECC_CORRECT_EN` defined: single-bit correction as described above.
- Undefined: detection only. Any S ≠ 0 sets `ecc_error`, H is passed uncorrected, the FSM goes to DROP, and `ecc_corrected` stays 0.

## Test plan
- sot; bytes 05 11 00 36 -> `hdr_valid`, `hdr_di`=05, `hdr_wc`=0011, `hdr_long`=0, no flags; the next 4 bytes are parsed as a new header.
- sot; 15 11 00 36 (bit 4 flipped) -> `hdr_di`=05, `ecc_corrected`=1 (with macro). Without macro: `ecc_error`=1, then DROP.
- sot; 06 11 00 36 (two bits flipped) -> `ecc_error`=1; following bytes ignored until the next `rx_sot`.
- sot; 39 00 00 0F FF FF -> `hdr_long`=1, no `pld_valid`, `crc_valid` with `crc_error`=0. Same with CRC bytes FE FF -> `crc_error`=1; with 00 00 -> `crc_error`=0.
- sot; long packet 39 WC=3 plus 3 payload bytes and bench-model CRC -> 3 `pld_valid` with `pld_last` on the 3rd, `crc_error`=0. Corrupt payload byte 2 -> `crc_error`=1.
- `rx_eot` after 2 payload bytes -> `pkt_abort` pulse, no `crc_valid`, state IDLE. `reset` mid-payload -> all outputs 0 the next cycle.
